// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter and sequencer for the shared synchronous-read data memory
// Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_W-1:0]     i_cpu_addr,
    input  logic [DATA_W-1:0]     i_cpu_wdata,
    input  logic [DATA_W/8-1:0]   i_cpu_be,
    output logic                  o_cpu_stall,
    output logic [DATA_W-1:0]     o_cpu_rdata,
    output logic                  o_cpu_rvalid,
    input  logic                  i_dbg_req,
    input  logic                  i_dbg_we,
    input  logic [ADDR_W-1:0]     i_dbg_addr,
    input  logic [DATA_W-1:0]     i_dbg_wdata,
    input  logic [DATA_W/8-1:0]   i_dbg_be,
    output logic                  o_dbg_gnt,
    output logic [DATA_W-1:0]     o_dbg_rdata,
    output logic                  o_dbg_rvalid,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;

    state_t r_state;
    state_t w_next;
    logic   w_force;
    logic   w_cpu_gnt;
    logic   w_dbg_gnt;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    logic [CNT_W-1:0] r_starve;

    assign w_force = (r_starve == CNT_W'(STARVE_LIM)) && i_dbg_req;

    // Counts consecutive IDLE cycles in which debug lost to the CPU.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (!i_dbg_req || w_dbg_gnt) begin
            r_starve <= '0;
        end else if (w_cpu_gnt && (r_starve != CNT_W'(STARVE_LIM))) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Reset gates the grants so every output is zero while it is held.
    assign w_cpu_gnt = !i_rst && (r_state == IDLE) && i_cpu_req && !w_force;
    assign w_dbg_gnt = !i_rst && (r_state == IDLE) && i_dbg_req && !w_cpu_gnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_cpu_stall  = 1'b0;
        o_cpu_rdata  = '0;
        o_cpu_rvalid = 1'b0;
        o_dbg_gnt    = 1'b0;
        o_dbg_rdata  = '0;
        o_dbg_rvalid = 1'b0;
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = '0;
        if (!i_rst) begin
            case (r_state)
                IDLE: begin
                    if (w_cpu_gnt) begin
                        o_mem_en    = 1'b1;
                        o_mem_we    = i_cpu_we;
                        o_mem_addr  = i_cpu_addr;
                        o_mem_wdata = i_cpu_wdata;
                        o_mem_be    = i_cpu_be;
                        o_cpu_stall = !i_cpu_we;
                        if (!i_cpu_we) begin
                            w_next = CPU_RD;
                        end
                    end else if (w_dbg_gnt) begin
                        o_dbg_gnt   = 1'b1;
                        o_mem_en    = 1'b1;
                        o_mem_we    = i_dbg_we;
                        o_mem_addr  = i_dbg_addr;
                        o_mem_wdata = i_dbg_wdata;
                        o_mem_be    = i_dbg_be;
                        o_cpu_stall = i_cpu_req;
                        if (!i_dbg_we) begin
                            w_next = DBG_RD;
                        end
                    end
                end
                // The held cpu_req here belongs to the load being returned.
                CPU_RD: begin
                    o_cpu_rvalid = 1'b1;
                    o_cpu_rdata  = i_mem_rdata;
                    w_next       = IDLE;
                end
                DBG_RD: begin
                    o_dbg_rvalid = 1'b1;
                    o_dbg_rdata  = i_mem_rdata;
                    o_cpu_stall  = i_cpu_req;
                    w_next       = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

endmodule
